mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory port between two cache-style requesters: port 0 = instruction cache, port 1 = data cache.
//  Both requesters use the cache memory protocol: a one-cycle rw_flag pulse per word, then a wait for a done pulse.
//  Sits between the caches' mem_* outputs and the memory controller.
//  Keeps cache refill bursts contiguous (burst lock) and bounds starvation with a lock limit.
// PARAMETERS
//  FAIR      1  1: round-robin on conflict (loser of the last conflict wins the next); 0: port 1 always wins
//  LOCK_MAX  8  max consecutive back-to-back issues by one owner while the other port waits (>=1)
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, asynchronous, active-high
//  pN_rw_flag      in   2   N=0,1; [0] read, [1] write; one-cycle request pulse
//  pN_addr         in   32  word address (bits[1:0] forwarded unchanged)
//  pN_write_data   in   32  write data
//  pN_write_mask   in   4   byte enables
//  pN_read_data    out  32  = mem_read_data (shared, valid only with pN_done)
//  pN_busy         out  1   pend[N] | (state==BUSY && owner==N)
//  pN_done         out  1   mem_done && state==BUSY && owner==N (combinational)
//  mem_rw_flag     out  2   registered; one-cycle pulse per transaction
//  mem_addr        out  32  registered with mem_rw_flag
//  mem_write_data  out  32  registered with mem_rw_flag
//  mem_write_mask  out  4   registered with mem_rw_flag
//  mem_read_data   in   32  memory read data
//  mem_busy        in   1   memory cannot accept a request
//  mem_done        in   1   completion pulse of the outstanding request
// BEHAVIOUR
//  Reset values: state=IDLE, owner=0, last=0, lock_cnt=0, pend=0, mem_* outputs=0.
//    Consequently pN_busy=0 and pN_done=0.
//  Per-port pending register: pend[N] plus captured flag/addr/data/mask.
//    A pulse that is not issued or forwarded in its arrival cycle is captured.
//  Candidate for port N = pend[N] ? captured request : (pN_rw_flag!=0 ? live inputs : none).
//  IDLE, !mem_busy, any candidate:
//    - Pick winner (FAIR: !last on conflict; else port 1).
//    - Register winner's request onto mem_* (visible next cycle); owner<=winner; clear pend[winner].
//    - State -> BUSY; lock_cnt<=0; on conflict, last<=winner.
//    - The loser is captured or stays pending.
//  IDLE with mem_busy: no issue; live requests are captured.
//  Latency: request pulse in cycle N with arbiter idle and !mem_busy -> mem_rw_flag high in N+1.
//  BUSY: mem_rw_flag drops to 0 after its single cycle; wait for mem_done.
//    mem_done in the pulse cycle is accepted.
//  BUSY, mem_done, owner pulses a new request in the same cycle (cache refill chaining):
//    - Forward it if !mem_busy and (other port has no candidate, or lock_cnt < LOCK_MAX-1).
//    - Forward: mem_* <= owner request, stay BUSY, lock_cnt++.
//  BUSY, mem_done, no forward:
//    - State -> IDLE; any owner pulse is captured into pend[owner].
//    - The other port wins in the next IDLE cycle if pending.
//  mem_done while IDLE: ignored, no pN_done.
//  A request while the port is already busy (and not on its own done cycle) is a protocol violation.
//    $display "Assertion Failed"; the request is dropped.
//  rw_flag=2'b11 is treated as write.
//  Async reset mid-transaction returns to reset values.
//    Later memory completions are ignored, because state=IDLE.
// STRUCTURE
//  Shared header (utility.v): `RW_NONE/`RW_READ/`RW_WRITE encodings, arbiter state localparams.
//  Sub-module arb_rr2: 2-way chooser (req[1:0], last, FAIR) -> grant, conflict.
//  The top holds the pend registers, FSM, lock counter and registered mem_* outputs.
// TESTING
//  1. Single request:
//     - Stimulus: p0 read 0x100 at cycle 2, mem_done at 5.
//     - Required: mem_rw_flag=01, addr 0x100 at cycle 3; p0_done at 5; p0_busy high during cycles 3-5.
//  2. Simultaneous requests, FAIR=1, last=0:
//     - Stimulus: p0 read 0x0 and p1 write 0x40 (data 0xDEADBEEF, mask 1111).
//     - Required: port 1 issued first; p0 issued in the cycle after p1_done; on a second conflict port 0 wins.
//  3. Burst lock:
//     - Stimulus: p0 chains 8 reads 0x200..0x21C, each issued on mem_done; p1 idle.
//     - Required: all 8 issue back-to-back, 1 cycle after each done; no IDLE in between.
//  4. Lock limit, LOCK_MAX=2:
//     - Stimulus: p0 chaining reads while p1 is pending.
//     - Required: p0 gets 2 issues, then p1 is issued; p0's third request is held in pend and issued after p1_done.
//  5. mem_busy:
//     - Stimulus: mem_busy=1 for 4 cycles while a p1 write pulses.
//     - Required: write captured; mem_rw_flag=10 one cycle after mem_busy falls; data/mask intact.
//  6. Reset in BUSY:
//     - Stimulus: assert rst, then mem_done.
//     - Required: all outputs 0 immediately; no pN_done after reset; the next request issues normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port cache memory arbiter:
// request encodings, arbiter state, the request bundle and the debug view.
package mem_arbiter_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_req_t;

  typedef struct packed {
    arb_state_e state;
    logic       owner;
    logic       last;
    logic [1:0] pend;
    logic       proto_err;
  } arb_dbg_t;

  // A flag with both bits set is a write.
  function automatic logic [1:0] norm_rw(input logic [1:0] rw);
    return rw[1] ? RW_WRITE : (rw[0] ? RW_READ : RW_NONE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache memory protocol bundle: one link between a requester (master) and a memory side (slave).
// Handshake: master pulses rw_flag non-zero for exactly one cycle per word, with addr/write_data/write_mask valid
// in that cycle, and only while busy is low; the slave answers with a one-cycle done pulse (read_data valid with it).
interface mem_arbiter_if;
  logic [1:0]  rw_flag;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        busy;
  logic        done;

  modport master (
    output rw_flag, addr, write_data, write_mask,
    input  read_data, busy, done
  );

  modport slave (
    input  rw_flag, addr, write_data, write_mask,
    output read_data, busy, done
  );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way chooser: a lone requester wins; on conflict the loser of the previous conflict wins
// when FAIR, otherwise port 1 always wins.
module mem_arbiter_arb_rr2 #(
  parameter bit FAIR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       conflict
);

  always_comb begin
    conflict = &req;
    if (conflict) grant = FAIR ? ~last : 1'b1;
    else          grant = req[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction cache (p0) and data cache (p1), keeping refill
// bursts contiguous while bounding how long the other port can be starved.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit FAIR     = 1'b1,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  mem_arbiter_if.master mem,
  output arb_dbg_t      dbg
);

  localparam int CW = $clog2(LOCK_MAX) + 1;
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX - 1);

  arb_state_e    state;
  logic          owner, last, proto_err;
  logic [CW-1:0] lock_cnt;
  logic [1:0]    pend;
  mem_req_t      cap_req [2];
  mem_req_t      mem_q;

  mem_req_t   live_req [2];
  mem_req_t   cand_req [2];
  logic [1:0] live_v, own_done, port_busy, viol, live_ok, cand, take;
  logic       grant, conflict, issue, fwd, other;

  always_comb begin
    live_req[0] = '{rw: norm_rw(p0.rw_flag), addr: p0.addr, wdata: p0.write_data, mask: p0.write_mask};
    live_req[1] = '{rw: norm_rw(p1.rw_flag), addr: p1.addr, wdata: p1.write_data, mask: p1.write_mask};
    for (int n = 0; n < 2; n++) begin
      live_v[n]    = live_req[n].rw != RW_NONE;
      own_done[n]  = (state == ST_BUSY) && (owner == 1'(n)) && mem.done;
      port_busy[n] = pend[n] || ((state == ST_BUSY) && (owner == 1'(n)));
      // A pulse from a busy port is dropped unless it chains on its own done.
      viol[n]      = live_v[n] && port_busy[n] && !own_done[n];
      live_ok[n]   = live_v[n] && !viol[n];
      cand[n]      = pend[n] || live_ok[n];
      cand_req[n]  = pend[n] ? cap_req[n] : live_req[n];
    end
  end

  mem_arbiter_arb_rr2 #(.FAIR(FAIR)) u_rr2 (
    .req      (cand),
    .last     (last),
    .grant    (grant),
    .conflict (conflict)
  );

  always_comb begin
    other = ~owner;
    issue = (state == ST_IDLE) && !mem.busy && (|cand);
    fwd   = (state == ST_BUSY) && mem.done && live_ok[owner] && !mem.busy &&
            (!cand[other] || (lock_cnt < LOCK_LIM));
    for (int n = 0; n < 2; n++)
      take[n] = (issue && (grant == 1'(n))) || (fwd && (owner == 1'(n)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      last      <= 1'b0;
      lock_cnt  <= '0;
      pend      <= '0;
      proto_err <= 1'b0;
      mem_q     <= '0;
      for (int n = 0; n < 2; n++) cap_req[n] <= '0;
    end else begin
      proto_err <= |viol;
      mem_q.rw  <= RW_NONE;
      for (int n = 0; n < 2; n++) begin
        if (take[n]) begin
          pend[n] <= 1'b0;
        end else if (live_ok[n] && !pend[n]) begin
          pend[n]    <= 1'b1;
          cap_req[n] <= live_req[n];
        end
      end
      case (state)
        ST_IDLE: begin
          if (issue) begin
            mem_q    <= cand_req[grant];
            owner    <= grant;
            state    <= ST_BUSY;
            lock_cnt <= '0;
            if (conflict) last <= grant;
          end
        end
        ST_BUSY: begin
          if (mem.done) begin
            if (fwd) begin
              mem_q <= live_req[owner];
              // Saturates at the limit so long uncontended bursts cannot wrap.
              if (lock_cnt != LOCK_LIM) lock_cnt <= lock_cnt + 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign p0.read_data = mem.read_data;
  assign p1.read_data = mem.read_data;
  assign p0.busy      = port_busy[0];
  assign p1.busy      = port_busy[1];
  assign p0.done      = own_done[0];
  assign p1.done      = own_done[1];

  assign mem.rw_flag    = mem_q.rw;
  assign mem.addr       = mem_q.addr;
  assign mem.write_data = mem_q.wdata;
  assign mem.write_mask = mem_q.mask;

  assign dbg = '{state: state, owner: owner, last: last, pend: pend, proto_err: proto_err};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a (LOCK_MAX=8) and instance b (LOCK_MAX=2).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if a_p0 ();
  mem_arbiter_if a_p1 ();
  mem_arbiter_if a_mem ();
  mem_arbiter_if b_p0 ();
  mem_arbiter_if b_p1 ();
  mem_arbiter_if b_mem ();
  arb_dbg_t a_dbg, b_dbg;

  mem_arbiter #(.FAIR(1'b1), .LOCK_MAX(8)) dut_a (
    .clk(clk), .rst(rst), .p0(a_p0), .p1(a_p1), .mem(a_mem), .dbg(a_dbg)
  );

  mem_arbiter #(.FAIR(1'b1), .LOCK_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .p0(b_p0), .p1(b_p1), .mem(b_mem), .dbg(b_dbg)
  );

  // ---------------- clock / cycle helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    a_p0.rw_flag = 2'b00; a_p1.rw_flag = 2'b00; a_mem.done = 1'b0;
    b_p0.rw_flag = 2'b00; b_p1.rw_flag = 2'b00; b_mem.done = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input int port, input logic [1:0] rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
    if (port == 0) begin
      a_p0.rw_flag = rw; a_p0.addr = addr; a_p0.write_data = data; a_p0.write_mask = mask;
    end else begin
      a_p1.rw_flag = rw; a_p1.addr = addr; a_p1.write_data = data; a_p1.write_mask = mask;
    end
  endtask

  task automatic drive_b(input int port, input logic [1:0] rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
    if (port == 0) begin
      b_p0.rw_flag = rw; b_p0.addr = addr; b_p0.write_data = data; b_p0.write_mask = mask;
    end else begin
      b_p1.rw_flag = rw; b_p1.addr = addr; b_p1.write_data = data; b_p1.write_mask = mask;
    end
  endtask

  task automatic init_inputs();
    drive_a(0, 2'b00, 32'h0, 32'h0, 4'h0);
    drive_a(1, 2'b00, 32'h0, 32'h0, 4'h0);
    drive_b(0, 2'b00, 32'h0, 32'h0, 4'h0);
    drive_b(1, 2'b00, 32'h0, 32'h0, 4'h0);
    a_mem.read_data = 32'h0; a_mem.busy = 1'b0; a_mem.done = 1'b0;
    b_mem.read_data = 32'h0; b_mem.busy = 1'b0; b_mem.done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    #2;
    a_mem.done = 1'b1;
    #1;
    checks++; if (a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL reset_rw got %b want 00", a_mem.rw_flag); end
    checks++; if (a_mem.addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", a_mem.addr); end
    checks++; if ({a_p0.busy, a_p1.busy} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b want 00", {a_p0.busy, a_p1.busy}); end
    checks++; if ({a_p0.done, a_p1.done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", {a_p0.done, a_p1.done}); end
    checks++; if (a_dbg !== '0) begin errors++; $display("FAIL reset_dbg got %h want 0", a_dbg); end
    checks++; if (b_mem.write_mask !== 4'h0) begin errors++; $display("FAIL reset_b_mask got %h want 0", b_mem.write_mask); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick(); drive_a(0, 2'b01, 32'h100, 32'h0, 4'h0); #1;
    checks++; if (a_p0.busy !== 1'b0) begin errors++; $display("FAIL single_busy_c2 got %b want 0", a_p0.busy); end
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b01) begin errors++; $display("FAIL single_rw got %b want 01", a_mem.rw_flag); end
    checks++; if (a_mem.addr !== 32'h100) begin errors++; $display("FAIL single_addr got %h want 100", a_mem.addr); end
    checks++; if (a_p0.busy !== 1'b1) begin errors++; $display("FAIL single_busy_c3 got %b want 1", a_p0.busy); end
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL single_rw_drop got %b want 00", a_mem.rw_flag); end
    checks++; if (a_p0.busy !== 1'b1) begin errors++; $display("FAIL single_busy_c4 got %b want 1", a_p0.busy); end
    tick(); a_mem.done = 1'b1; a_mem.read_data = 32'h12345678; #1;
    checks++; if (a_p0.done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", a_p0.done); end
    checks++; if (a_p0.read_data !== 32'h12345678) begin errors++; $display("FAIL single_rdata got %h want 12345678", a_p0.read_data); end
    checks++; if (a_p1.done !== 1'b0) begin errors++; $display("FAIL single_p1_done got %b want 0", a_p1.done); end
    checks++; if (a_p0.busy !== 1'b1) begin errors++; $display("FAIL single_busy_c5 got %b want 1", a_p0.busy); end
    tick(); #1;
    checks++; if (a_p0.busy !== 1'b0) begin errors++; $display("FAIL single_busy_c6 got %b want 0", a_p0.busy); end
    checks++; if (a_dbg.state !== ST_IDLE) begin errors++; $display("FAIL single_idle got %b want 0", a_dbg.state); end
  endtask

  task automatic test_conflict();
    tick();
    drive_a(0, 2'b01, 32'h0, 32'h0, 4'h0);
    drive_a(1, 2'b10, 32'h40, 32'hDEADBEEF, 4'hF);
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b10) begin errors++; $display("FAIL conf1_rw got %b want 10", a_mem.rw_flag); end
    checks++; if (a_mem.addr !== 32'h40) begin errors++; $display("FAIL conf1_addr got %h want 40", a_mem.addr); end
    checks++; if (a_mem.write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL conf1_data got %h want deadbeef", a_mem.write_data); end
    checks++; if (a_mem.write_mask !== 4'hF) begin errors++; $display("FAIL conf1_mask got %h want f", a_mem.write_mask); end
    checks++; if (a_p0.busy !== 1'b1) begin errors++; $display("FAIL conf1_p0_pend got %b want 1", a_p0.busy); end
    tick(); a_mem.done = 1'b1; #1;
    checks++; if ({a_p1.done, a_p0.done} !== 2'b10) begin errors++; $display("FAIL conf1_done got %b want 10", {a_p1.done, a_p0.done}); end
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL conf1_gap got %b want 00", a_mem.rw_flag); end
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b01 || a_mem.addr !== 32'h0) begin errors++; $display("FAIL conf1_p0_issue got %b/%h want 01/0", a_mem.rw_flag, a_mem.addr); end
    checks++; if (a_dbg.owner !== 1'b0) begin errors++; $display("FAIL conf1_owner got %b want 0", a_dbg.owner); end
    tick(); a_mem.done = 1'b1;
    tick();
    drive_a(0, 2'b01, 32'h8, 32'h0, 4'h0);
    drive_a(1, 2'b01, 32'h48, 32'h0, 4'h0);
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b01 || a_mem.addr !== 32'h8) begin errors++; $display("FAIL conf2_p0_wins got %b/%h want 01/8", a_mem.rw_flag, a_mem.addr); end
    checks++; if (a_p1.busy !== 1'b1) begin errors++; $display("FAIL conf2_p1_pend got %b want 1", a_p1.busy); end
    tick(); a_mem.done = 1'b1;
    tick();
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b01 || a_mem.addr !== 32'h48) begin errors++; $display("FAIL conf2_p1_issue got %b/%h want 01/48", a_mem.rw_flag, a_mem.addr); end
    tick(); a_mem.done = 1'b1; #1;
    checks++; if (a_p1.done !== 1'b1) begin errors++; $display("FAIL conf2_p1_done got %b want 1", a_p1.done); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    tick(); drive_a(0, 2'b01, 32'h200, 32'h0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      exp_addr = 32'h200 + 32'(4 * i);
      tick(); #1;
      checks++; if (a_mem.rw_flag !== 2'b01 || a_mem.addr !== exp_addr) begin errors++; $display("FAIL burst_issue%0d got %b/%h want 01/%h", i, a_mem.rw_flag, a_mem.addr, exp_addr); end
      checks++; if (a_dbg.state !== ST_BUSY) begin errors++; $display("FAIL burst_state%0d got %b want 1", i, a_dbg.state); end
      tick(); a_mem.done = 1'b1;
      if (i < 7) drive_a(0, 2'b01, exp_addr + 32'h4, 32'h0, 4'h0);
      #1;
      checks++; if (a_p0.done !== 1'b1 || a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL burst_done%0d got %b/%b want 1/00", i, a_p0.done, a_mem.rw_flag); end
    end
    tick(); #1;
    checks++; if (a_dbg.state !== ST_IDLE || a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL burst_end got %b/%b want 0/00", a_dbg.state, a_mem.rw_flag); end
  endtask

  task automatic test_lock_limit();
    tick(); drive_b(0, 2'b01, 32'h300, 32'h0, 4'h0);
    tick(); #1;
    checks++; if (b_mem.rw_flag !== 2'b01 || b_mem.addr !== 32'h300) begin errors++; $display("FAIL lock_issue1 got %b/%h want 01/300", b_mem.rw_flag, b_mem.addr); end
    drive_b(1, 2'b10, 32'h500, 32'hCAFEF00D, 4'h3);
    tick(); b_mem.done = 1'b1; drive_b(0, 2'b01, 32'h304, 32'h0, 4'h0); #1;
    checks++; if (b_p0.done !== 1'b1 || b_p1.busy !== 1'b1) begin errors++; $display("FAIL lock_done1 got %b/%b want 1/1", b_p0.done, b_p1.busy); end
    tick(); #1;
    checks++; if (b_mem.rw_flag !== 2'b01 || b_mem.addr !== 32'h304) begin errors++; $display("FAIL lock_issue2 got %b/%h want 01/304", b_mem.rw_flag, b_mem.addr); end
    tick(); b_mem.done = 1'b1; drive_b(0, 2'b01, 32'h308, 32'h0, 4'h0); #1;
    checks++; if (b_p0.done !== 1'b1) begin errors++; $display("FAIL lock_done2 got %b want 1", b_p0.done); end
    tick(); #1;
    checks++; if (b_dbg.state !== ST_IDLE || b_dbg.pend !== 2'b11) begin errors++; $display("FAIL lock_release got %b/%b want 0/11", b_dbg.state, b_dbg.pend); end
    tick(); #1;
    checks++; if (b_mem.rw_flag !== 2'b10 || b_mem.addr !== 32'h500) begin errors++; $display("FAIL lock_p1_issue got %b/%h want 10/500", b_mem.rw_flag, b_mem.addr); end
    checks++; if (b_mem.write_data !== 32'hCAFEF00D || b_mem.write_mask !== 4'h3) begin errors++; $display("FAIL lock_p1_data got %h/%h want cafef00d/3", b_mem.write_data, b_mem.write_mask); end
    checks++; if (b_p0.busy !== 1'b1) begin errors++; $display("FAIL lock_p0_held got %b want 1", b_p0.busy); end
    tick(); b_mem.done = 1'b1; #1;
    checks++; if (b_p1.done !== 1'b1) begin errors++; $display("FAIL lock_p1_done got %b want 1", b_p1.done); end
    tick();
    tick(); #1;
    checks++; if (b_mem.rw_flag !== 2'b01 || b_mem.addr !== 32'h308) begin errors++; $display("FAIL lock_p0_third got %b/%h want 01/308", b_mem.rw_flag, b_mem.addr); end
    tick(); b_mem.done = 1'b1; #1;
    checks++; if (b_p0.done !== 1'b1) begin errors++; $display("FAIL lock_p0_done3 got %b want 1", b_p0.done); end
    tick();
  endtask

  task automatic test_mem_busy();
    tick(); a_mem.busy = 1'b1;
    tick(); drive_a(1, 2'b11, 32'h600, 32'h0BADC0DE, 4'h5);
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL mbusy_hold got %b want 00", a_mem.rw_flag); end
    checks++; if (a_p1.busy !== 1'b1) begin errors++; $display("FAIL mbusy_captured got %b want 1", a_p1.busy); end
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL mbusy_hold2 got %b want 00", a_mem.rw_flag); end
    tick(); a_mem.busy = 1'b0;
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b10 || a_mem.addr !== 32'h600) begin errors++; $display("FAIL mbusy_issue got %b/%h want 10/600", a_mem.rw_flag, a_mem.addr); end
    checks++; if (a_mem.write_data !== 32'h0BADC0DE || a_mem.write_mask !== 4'h5) begin errors++; $display("FAIL mbusy_data got %h/%h want 0badc0de/5", a_mem.write_data, a_mem.write_mask); end
    tick(); a_mem.done = 1'b1; #1;
    checks++; if (a_p1.done !== 1'b1) begin errors++; $display("FAIL mbusy_done got %b want 1", a_p1.done); end
    tick();
  endtask

  task automatic test_violation();
    tick(); drive_a(0, 2'b01, 32'h900, 32'h0, 4'h0);
    tick(); drive_a(0, 2'b01, 32'h904, 32'h0, 4'h0);
    tick(); #1;
    checks++; if (a_dbg.proto_err !== 1'b1 || a_dbg.pend !== 2'b00) begin errors++; $display("FAIL viol_flag got %b/%b want 1/00", a_dbg.proto_err, a_dbg.pend); end
    tick(); a_mem.done = 1'b1; #1;
    checks++; if (a_dbg.proto_err !== 1'b0) begin errors++; $display("FAIL viol_clear got %b want 0", a_dbg.proto_err); end
    tick(); #1;
    checks++; if (a_p0.busy !== 1'b0 || a_mem.rw_flag !== 2'b00) begin errors++; $display("FAIL viol_dropped got %b/%b want 0/00", a_p0.busy, a_mem.rw_flag); end
  endtask

  task automatic test_reset_busy();
    tick(); drive_a(0, 2'b01, 32'h700, 32'h0, 4'h0);
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b01) begin errors++; $display("FAIL rstb_issue got %b want 01", a_mem.rw_flag); end
    rst = 1'b1; #1;
    checks++; if (a_mem.rw_flag !== 2'b00 || a_mem.addr !== 32'h0) begin errors++; $display("FAIL rstb_outputs got %b/%h want 00/0", a_mem.rw_flag, a_mem.addr); end
    checks++; if (a_p0.busy !== 1'b0 || a_dbg.state !== ST_IDLE) begin errors++; $display("FAIL rstb_state got %b/%b want 0/0", a_p0.busy, a_dbg.state); end
    tick(); a_mem.done = 1'b1; #1;
    rst = 1'b0; #1;
    checks++; if (a_p0.done !== 1'b0) begin errors++; $display("FAIL rstb_late_done got %b want 0", a_p0.done); end
    tick(); drive_a(1, 2'b01, 32'h800, 32'h0, 4'h0);
    tick(); #1;
    checks++; if (a_mem.rw_flag !== 2'b01 || a_mem.addr !== 32'h800) begin errors++; $display("FAIL rstb_next got %b/%h want 01/800", a_mem.rw_flag, a_mem.addr); end
    tick(); a_mem.done = 1'b1; #1;
    checks++; if (a_p1.done !== 1'b1) begin errors++; $display("FAIL rstb_next_done got %b want 1", a_p1.done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_back_to_back();
    test_lock_limit();
    test_mem_busy();
    test_violation();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
